// File: rtl/tpu_pkg.sv
// Shared definitions for the systolic-array tile: data format, default array size
// and the tile sequencer state encoding.
package tpu_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    localparam int SA_N = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_W,
        ST_SWITCH,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } tile_state_t;

endpackage

// File: rtl/pe_skew_line.sv
// Row skew line: output bit r is the input delayed by r cycles, so bit 0 follows
// the input directly. The caller feeds a registered signal, which keeps every
// output bit registered. Flush empties the line in one edge.
module pe_skew_line #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         din,
    output logic [N-1:0] dout
);

    logic [N-2:0] taps;

    // Shift the input down the delay taps, one row per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps <= '0;
        end else if (flush) begin
            taps <= '0;
        end else begin
            taps <= (taps << 1) | (N-1)'(din);
        end
    end

    assign dout = {taps, din};

endmodule

// File: rtl/sa_tile_ctrl.sv
// Weight-stationary tile sequencer: loads N weight rows bottom-first, fires a
// skewed switch wave, streams M input vectors with row skew, waits for the array
// to drain and pulses done. Only control and addresses are produced here.
module sa_tile_ctrl
    import tpu_pkg::*;
#(
    parameter int N      = SA_N,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_w_base,
    input  logic [ADDR_W-1:0] cmd_x_base,
    input  logic [CNT_W-1:0]  cmd_rows,
    input  logic              abort,
    output logic              wmem_rd_en,
    output logic [ADDR_W-1:0] wmem_addr,
    output logic              imem_rd_en,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              sa_accept_w,
    output logic [N-1:0]      sa_switch,
    output logic [N-1:0]      sa_valid,
    output logic [N-1:0]      sa_enabled,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0]  LOAD_LAST  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0]  DRAIN_LAST = CNT_W'(2 * N - 1);
    localparam logic [ADDR_W-1:0] W_TOP      = ADDR_W'(N - 1);

    tile_state_t       state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [ADDR_W-1:0] w_base_q, x_base_q;
    logic [CNT_W-1:0]  rows_q;
    logic              accept;
    logic              switch_q;
    logic              valid_q;

    assign cmd_ready  = (state == ST_IDLE);
    assign accept     = cmd_valid && cmd_ready && !abort;
    assign busy       = (state != ST_IDLE);
    assign sa_enabled = {N{busy}};

    // State, phase counter and the command fields captured at acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            w_base_q <= '0;
            x_base_q <= '0;
            rows_q   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                w_base_q <= cmd_w_base;
                x_base_q <= cmd_x_base;
                rows_q   <= cmd_rows;
            end
        end
    end

    // Phase sequencing and memory strobes; abort from any busy state returns to idle
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        wmem_rd_en = 1'b0;
        wmem_addr  = '0;
        imem_rd_en = 1'b0;
        imem_addr  = '0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_LOAD_W;
                    cnt_next   = '0;
                end
            end
            ST_LOAD_W: begin
                wmem_rd_en = 1'b1;
                wmem_addr  = w_base_q + W_TOP - ADDR_W'(cnt);
                if (cnt == LOAD_LAST) begin
                    state_next = ST_SWITCH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_SWITCH: begin
                cnt_next   = '0;
                state_next = (rows_q == '0) ? ST_DRAIN : ST_STREAM;
            end
            ST_STREAM: begin
                imem_rd_en = 1'b1;
                imem_addr  = x_base_q + ADDR_W'(cnt);
                if (cnt == rows_q - CNT_W'(1)) begin
                    state_next = ST_DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (cnt == DRAIN_LAST) begin
                    state_next = ST_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
        if (abort && (state != ST_IDLE)) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end
    end

    // Strobes that follow the 1-cycle memory latency: weight accept, switch seed, valid seed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sa_accept_w <= 1'b0;
            switch_q    <= 1'b0;
            valid_q     <= 1'b0;
        end else if (abort) begin
            sa_accept_w <= 1'b0;
            switch_q    <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            sa_accept_w <= wmem_rd_en;
            switch_q    <= (state == ST_SWITCH);
            valid_q     <= imem_rd_en;
        end
    end

    pe_skew_line #(.N(N)) u_switch_line (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .din   (switch_q),
        .dout  (sa_switch)
    );

    pe_skew_line #(.N(N)) u_valid_line (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .din   (valid_q),
        .dout  (sa_valid)
    );

endmodule

// File: tb/tb_sa_tile_ctrl.sv
// Self-checking bench for sa_tile_ctrl: directed scenarios plus random commands,
// compared every cycle against a cycle-number model of the operation timeline.
module tb_sa_tile_ctrl;

    localparam int N      = 2;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_w_base;
    logic [ADDR_W-1:0] cmd_x_base;
    logic [CNT_W-1:0]  cmd_rows;
    logic              abort;
    logic              wmem_rd_en;
    logic [ADDR_W-1:0] wmem_addr;
    logic              imem_rd_en;
    logic [ADDR_W-1:0] imem_addr;
    logic              sa_accept_w;
    logic [N-1:0]      sa_switch;
    logic [N-1:0]      sa_valid;
    logic [N-1:0]      sa_enabled;
    logic              busy;
    logic              done;

    int compared   = 0;
    int mismatched = 0;

    bit             m_active = 1'b0;
    int             m_k      = 0;
    logic [7:0]     m_w      = '0;
    logic [7:0]     m_x      = '0;
    int             m_m      = 0;
    int             m_accepts   = 0;
    int             dut_accepts = 0;

    sa_tile_ctrl #(.N(N), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_w_base  (cmd_w_base),
        .cmd_x_base  (cmd_x_base),
        .cmd_rows    (cmd_rows),
        .abort       (abort),
        .wmem_rd_en  (wmem_rd_en),
        .wmem_addr   (wmem_addr),
        .imem_rd_en  (imem_rd_en),
        .imem_addr   (imem_addr),
        .sa_accept_w (sa_accept_w),
        .sa_switch   (sa_switch),
        .sa_valid    (sa_valid),
        .sa_enabled  (sa_enabled),
        .busy        (busy),
        .done        (done)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, k=%0d)", tag, observed, expected, $time, m_k);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] wb, input logic [7:0] xb,
                                 input logic [7:0] rows, input logic ab);
        cmd_valid  = v;
        cmd_w_base = wb;
        cmd_x_base = xb;
        cmd_rows   = rows;
        abort      = ab;
    endtask

    // Expected outputs for the current cycle, derived from the cycle number since acceptance
    task automatic checkAll();
        logic       e_wrd, e_ird, e_acc, e_done, e_busy;
        logic [7:0] e_waddr, e_iaddr;
        logic [N-1:0] e_sw, e_vl;
        e_wrd = 0; e_ird = 0; e_acc = 0; e_done = 0; e_busy = 0;
        e_waddr = '0; e_iaddr = '0; e_sw = '0; e_vl = '0;
        if (m_active) begin
            e_busy = 1;
            e_wrd  = (m_k >= 1) && (m_k <= N);
            if (e_wrd) e_waddr = m_w + 8'(N - m_k);
            e_acc  = (m_k >= 2) && (m_k <= N + 1);
            e_ird  = (m_k >= N + 2) && (m_k <= N + 1 + m_m);
            if (e_ird) e_iaddr = m_x + 8'(m_k - N - 2);
            for (int r = 0; r < N; r++) begin
                e_sw[r] = (m_k == N + 2 + r);
                e_vl[r] = (m_k >= N + 3 + r) && (m_k <= N + 2 + m_m + r);
            end
            e_done = (m_k == 3 * N + m_m + 2);
        end
        checkOutput("cmd_ready",   32'(cmd_ready),   32'(!m_active));
        checkOutput("busy",        32'(busy),        32'(e_busy));
        checkOutput("sa_enabled",  32'(sa_enabled),  32'({N{e_busy}}));
        checkOutput("wmem_rd_en",  32'(wmem_rd_en),  32'(e_wrd));
        checkOutput("wmem_addr",   32'(wmem_addr),   32'(e_waddr));
        checkOutput("sa_accept_w", 32'(sa_accept_w), 32'(e_acc));
        checkOutput("sa_switch",   32'(sa_switch),   32'(e_sw));
        checkOutput("imem_rd_en",  32'(imem_rd_en),  32'(e_ird));
        checkOutput("imem_addr",   32'(imem_addr),   32'(e_iaddr));
        checkOutput("sa_valid",    32'(sa_valid),    32'(e_vl));
        checkOutput("done",        32'(done),        32'(e_done));
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then check
    task automatic stepCycle();
        if (cmd_ready && cmd_valid && !abort) dut_accepts++;
        @(posedge clk);
        if (!m_active) begin
            if (cmd_valid && !abort) begin
                m_active = 1'b1;
                m_k      = 1;
                m_w      = cmd_w_base;
                m_x      = cmd_x_base;
                m_m      = int'(cmd_rows);
                m_accepts++;
            end
        end else if (abort) begin
            m_active = 1'b0;
        end else if (m_k == 3 * N + m_m + 2) begin
            m_active = 1'b0;
        end else begin
            m_k++;
        end
        #1;
        checkAll();
    endtask

    task automatic runCommand(input logic [7:0] wb, input logic [7:0] xb, input logic [7:0] rows, input int cycles);
        applyStimulus(1, wb, xb, rows, 0);
        stepCycle();
        applyStimulus(0, 8'h00, 8'h00, 8'h00, 0);
        repeat (cycles) stepCycle();
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        int acc_before_dut, acc_before_model;
        rst = 1'b1;
        applyStimulus(0, 8'h00, 8'h00, 8'h00, 0);
        repeat (2) @(posedge clk);
        #1;
        checkAll();
        rst = 1'b0;

        $display("[TB] basic command M=3");
        runCommand(8'h10, 8'h40, 8'd3, 14);

        $display("[TB] command with M=0");
        runCommand(8'h10, 8'h40, 8'd0, 10);

        $display("[TB] abort during cycle 5");
        applyStimulus(1, 8'h10, 8'h40, 8'd3, 0);
        stepCycle();
        applyStimulus(0, 8'h00, 8'h00, 8'h00, 0);
        repeat (4) stepCycle();
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        repeat (8) stepCycle();
        runCommand(8'h10, 8'h40, 8'd3, 14);

        $display("[TB] abort coinciding with a command in idle");
        applyStimulus(1, 8'h22, 8'h33, 8'd2, 1);
        stepCycle();
        applyStimulus(0, 8'h00, 8'h00, 8'h00, 0);
        repeat (3) stepCycle();

        $display("[TB] weight address wrap");
        runCommand(8'hFF, 8'hFE, 8'd3, 14);

        $display("[TB] back-to-back commands");
        acc_before_dut   = dut_accepts;
        acc_before_model = m_accepts;
        applyStimulus(1, 8'h05, 8'h80, 8'd1, 0);
        repeat (20) stepCycle();
        applyStimulus(0, 8'h00, 8'h00, 8'h00, 0);
        repeat (14) stepCycle();
        checkOutput("b2b_model_accepts", 32'(m_accepts - acc_before_model), 32'd2);
        checkOutput("b2b_dut_accepts", 32'(dut_accepts - acc_before_dut), 32'(m_accepts - acc_before_model));

        $display("[TB] reset between edges during streaming");
        applyStimulus(1, 8'h10, 8'h40, 8'd3, 0);
        stepCycle();
        applyStimulus(0, 8'h00, 8'h00, 8'h00, 0);
        repeat (4) stepCycle();
        #2;
        rst = 1'b1;
        m_active = 1'b0;
        #1;
        checkAll();
        #1;
        rst = 1'b0;
        runCommand(8'h10, 8'h40, 8'd3, 14);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom),
                          8'($urandom_range(0, 5)), ($urandom_range(0, 29) == 0));
            stepCycle();
        end
        applyStimulus(0, 8'h00, 8'h00, 8'h00, 0);
        repeat (20) stepCycle();
        checkOutput("total_accepts", 32'(dut_accepts), 32'(m_accepts));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
